core_s1_fetch_ctrl: RTL
=======================

// Module: core_s1_fetch_ctrl
// PURPOSE
//  Stage-1 fetch sequencer between the MMU instruction port and s2.
//  Owns the PC, issues one-at-a-time fetch requests and buffers returned instructions for s2.
//  Applies s2 branch redirects and discards stale in-flight responses.
//  Halts after a fetch fault until the next redirect.
// PARAMETERS
//  RESET_PC   32'h00000000   PC of the first fetch after reset (core_pkg::RESET_PC)
// PORTS
//  i_clk              in   1   core clock
//  i_rst              in   1   reset; synchronous, active-high
//  o_req_valid        out  1   fetch request to MMU is valid
//  o_req_addr         out  32  fetch address; word-aligned
//  i_rsp_ready        in   1   response valid this cycle; completes the current request
//  i_rsp_instr        in   32  fetched instruction; sampled only when i_rsp_ready
//  i_rsp_illegal      in   1   fetch access fault; sampled only when i_rsp_ready
//  i_branch_en        in   1   redirect from s2
//  i_branch_target    in   32  redirect PC
//  o_s2_valid         out  1   o_s2_pc/instr/fault valid (core_pkg::s1_to_s2_s.valid)
//  o_s2_pc            out  32  PC of o_s2_instr
//  o_s2_instr         out  32  instruction
//  o_s2_fault         out  1   entry is a fault (illegal or misaligned); instr = 0
//  i_s2_ready         in   1   s2 consumes the entry this cycle when o_s2_valid
// BEHAVIOUR
//  Reset values: o_req_valid=0, o_req_addr=RESET_PC, o_s2_valid=0, o_s2_pc=0, o_s2_instr=0, o_s2_fault=0.
//  Reset also clears the skid buffer, the state register (to FETCH) and the PC (to RESET_PC).
//  Reset mid-request: the request is abandoned; the MMU shares i_rst.
//  Request rule:
//   - Once o_req_valid=1, o_req_valid and o_req_addr stay stable until the cycle with i_rsp_ready=1.
//   - Responses may arrive in the same cycle as the request or any number of cycles later.
//   - A new request starts only when the skid buffer is empty and (o_s2_valid=0 or i_s2_ready=1).
//  Throughput: 1 instr/cycle when i_rsp_ready and i_s2_ready are held high.
//   - The PC advances by 4 on each accepted response.
//  Buffering: a registered output entry plus a 1-entry skid buffer.
//   - A response that arrives while the output entry is held (i_s2_ready=0) goes to the skid buffer.
//   - The skid buffer refills the output entry first; order is preserved.
//  States:
//   FETCH   normal operation
//   DISCARD a redirect arrived while a request was outstanding
//           - keep o_req_addr at the old address until i_rsp_ready
//           - drop that response, then go to FETCH with PC = target
//   HALT    a fault entry was produced; no further requests until a redirect
//  Fault handling:
//   - i_rsp_illegal=1 -> entry {pc, instr=0, fault=1}, then HALT.
//   - Branch target with [1:0]!=0 -> no request is issued.
//     - The next cycle produces a fault entry {pc=target, fault=1}, then HALT.
//  Redirect (priority over everything):
//   - The output and skid entries are invalidated the next cycle, including any entry being accepted this cycle.
//   - Redirect in the same cycle as i_rsp_ready -> the response is dropped; the target request is issued next cycle (FETCH).
//   - Redirect with a request outstanding and no i_rsp_ready -> DISCARD.
//   - Redirect while in DISCARD -> the target is updated; the state stays DISCARD.
//   - Redirect while in HALT -> FETCH at the target.
//  o_s2_* are registered; i_rsp_* have no combinational path to o_s2_*.
//  o_req_valid may combinationally depend on i_s2_ready (request issue rule above).
// STRUCTURE
//  core_pkg additions:
//   - fetch_state_e {FETCH, DISCARD, HALT}
//   - fetch_entry_s {pc, instr, fault}
//   - s1_to_s2_s gains a fault field
//  Sub-module: core_s1_fetch_buf.
//   - 2-entry in-order buffer (output register + skid).
//   - push/pop/flush; reports count.
//  The FSM and PC logic stay in core_s1_fetch_ctrl.
// TESTING
//  1. Reset released; i_rsp_ready=1, i_s2_ready=1 continuously
//     -> requests 0x0,0x4,0x8,... on consecutive cycles; o_s2_pc follows 1 cycle behind.
//  2. i_s2_ready=0 for 5 cycles while responses keep coming
//     -> at most 2 entries buffered; o_req_valid drops.
//     -> i_s2_ready reasserted gives the PCs in order, with no loss and no duplicates.
//  3. Request 0x10 outstanding, rsp delayed 3 cycles; i_branch_en with target 0x100 in cycle 1
//     -> o_req_addr stays 0x10 until ready; response is dropped; next request is 0x100.
//     -> no 0x10 entry appears at s2.
//  4. i_branch_en (target 0x200) in the same cycle as i_rsp_ready for 0x20
//     -> 0x20 is never presented; the next request is 0x200.
//  5. i_rsp_illegal=1 on 0x30
//     -> o_s2_fault=1, pc=0x30, instr=0; no requests until a redirect to 0x40 resumes fetch at 0x40.
//  6. Redirect to 0x102
//     -> no request; fault entry pc=0x102; HALT.
//     -> i_rst asserted mid-request -> next cycle all outputs are at reset values; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core types: fetch-stage state, buffered fetch entries and the s1->s2 bundle.
package core_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DISCARD = 2'd1,
    HALT    = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_s;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } s1_to_s2_s;

  function automatic logic is_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/core_s1_fetch_buf.sv
// Two-entry in-order fetch buffer: a registered output entry backed by one skid entry.
module core_s1_fetch_buf
  import core_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  fetch_entry_s i_push_entry,
  input  logic         i_pop,
  input  logic         i_flush,
  output logic         o_valid,
  output fetch_entry_s o_entry,
  output logic [1:0]   o_count
);

  fetch_entry_s r_out;
  fetch_entry_s r_skid;
  logic         r_out_valid;
  logic         r_skid_valid;
  logic         w_out_free;

  assign w_out_free = !r_out_valid || i_pop;

  // The skid entry always drains into the output slot before a new push can land there.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_out        <= '0;
      r_skid       <= '0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= i_push;
        if (i_push) r_skid <= i_push_entry;
      end else begin
        r_out_valid <= i_push;
        if (i_push) r_out <= i_push_entry;
      end
    end else if (i_push) begin
      r_skid       <= i_push_entry;
      r_skid_valid <= 1'b1;
    end
  end

  assign o_valid = r_out_valid;
  assign o_entry = r_out;
  assign o_count = {1'b0, r_out_valid} + {1'b0, r_skid_valid};

endmodule

// File: rtl/core_s1_fetch_ctrl.sv
// Stage-1 fetch sequencer: owns the PC, issues one fetch at a time, buffers results for s2
// and handles redirects, stale responses and fetch faults.
module core_s1_fetch_ctrl
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = core_pkg::RESET_PC
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_req_valid,
  output logic [31:0] o_req_addr,
  input  logic        i_rsp_ready,
  input  logic [31:0] i_rsp_instr,
  input  logic        i_rsp_illegal,
  input  logic        i_branch_en,
  input  logic [31:0] i_branch_target,
  output logic        o_s2_valid,
  output logic [31:0] o_s2_pc,
  output logic [31:0] o_s2_instr,
  output logic        o_s2_fault,
  input  logic        i_s2_ready
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_nxt;
  logic [31:0]  r_target;
  logic [31:0]  w_target_nxt;
  logic         r_pending;
  logic         w_pending_nxt;

  logic         w_room;
  logic         w_misaligned;
  logic         w_rsp_take;
  logic         w_push;
  logic         w_pop;
  logic         w_flush;
  fetch_entry_s w_push_entry;
  logic         w_out_valid;
  fetch_entry_s w_out_entry;
  logic [1:0]   w_count;
  s1_to_s2_s    w_s2;

  // Room for a new entry exists only when the skid is empty and the output slot frees up.
  assign w_room       = (w_count == 2'd0) || ((w_count == 2'd1) && i_s2_ready);
  assign w_misaligned = !is_aligned(r_pc);
  assign o_req_valid  = !i_rst && (r_pending || ((r_state == FETCH) && !w_misaligned && w_room));
  assign o_req_addr   = {r_pc[31:2], 2'b00};
  assign w_rsp_take   = o_req_valid && i_rsp_ready;
  assign w_pop        = w_out_valid && i_s2_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= FETCH;
      r_pc      <= RESET_PC;
      r_target  <= RESET_PC;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_target  <= w_target_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  // A redirect overrides everything; an outstanding request must still be drained in DISCARD.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_target_nxt  = r_target;
    w_pending_nxt = o_req_valid && !i_rsp_ready;
    w_push        = 1'b0;
    w_push_entry  = '0;
    w_flush       = 1'b0;
    if (i_branch_en) begin
      w_flush = 1'b1;
      if (o_req_valid && !i_rsp_ready) begin
        w_state_nxt  = DISCARD;
        w_target_nxt = i_branch_target;
      end else begin
        w_state_nxt = FETCH;
        w_pc_nxt    = i_branch_target;
      end
    end else begin
      case (r_state)
        FETCH: begin
          if (w_rsp_take) begin
            w_push = 1'b1;
            if (i_rsp_illegal) begin
              w_push_entry = '{pc: r_pc, instr: 32'h0, fault: 1'b1};
              w_state_nxt  = HALT;
            end else begin
              w_push_entry = '{pc: r_pc, instr: i_rsp_instr, fault: 1'b0};
              w_pc_nxt     = r_pc + 32'd4;
            end
          end else if (w_misaligned && w_room && !r_pending) begin
            w_push       = 1'b1;
            w_push_entry = '{pc: r_pc, instr: 32'h0, fault: 1'b1};
            w_state_nxt  = HALT;
          end
        end
        DISCARD: begin
          if (w_rsp_take) begin
            w_state_nxt = FETCH;
            w_pc_nxt    = r_target;
          end
        end
        HALT: begin
          w_state_nxt = HALT;
        end
        default: begin
          w_state_nxt = FETCH;
        end
      endcase
    end
  end

  core_s1_fetch_buf u_buf (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .i_flush      (w_flush),
    .o_valid      (w_out_valid),
    .o_entry      (w_out_entry),
    .o_count      (w_count)
  );

  assign w_s2       = {w_out_valid, w_out_entry.pc, w_out_entry.instr, w_out_entry.fault};
  assign o_s2_valid = w_s2.valid;
  assign o_s2_pc    = w_s2.pc;
  assign o_s2_instr = w_s2.instr;
  assign o_s2_fault = w_s2.fault;

endmodule
